// File: rtl/armv8_ctrl_pkg.sv
// armv8_ctrl_pkg: opcode patterns, ALU/sign-extend encodings and FSM/class enums for the ARMv8 control units
package armv8_ctrl_pkg;
    localparam logic [10:0] OPCODE_LDUR   = 11'b11111000010;
    localparam logic [10:0] OPCODE_STUR   = 11'b11111000000;
    localparam logic [10:0] OPCODE_ADDREG = 11'b10001011000;
    localparam logic [10:0] OPCODE_ADDIMM = 11'b1001000100?;
    localparam logic [10:0] OPCODE_SUBREG = 11'b11001011000;
    localparam logic [10:0] OPCODE_SUBIMM = 11'b1101000100?;
    localparam logic [10:0] OPCODE_AND    = 11'b10001010000;
    localparam logic [10:0] OPCODE_ORR    = 11'b10101010000;
    localparam logic [10:0] OPCODE_CBZ    = 11'b10110100???;
    localparam logic [10:0] OPCODE_B      = 11'b000101?????;
    localparam logic [10:0] OPCODE_MOVZ   = 11'b110100101??;

    localparam logic [3:0] ALUOP_ADD   = 4'b0010;
    localparam logic [3:0] ALUOP_SUB   = 4'b0110;
    localparam logic [3:0] ALUOP_AND   = 4'b0000;
    localparam logic [3:0] ALUOP_ORR   = 4'b0001;
    localparam logic [3:0] ALUOP_PASSB = 4'b0111;

    localparam logic [2:0] SIGNOP_D    = 3'b000;
    localparam logic [2:0] SIGNOP_I    = 3'b001;
    localparam logic [2:0] SIGNOP_CB   = 3'b010;
    localparam logic [2:0] SIGNOP_B    = 3'b011;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_LDUR, CLS_STUR, CLS_ADDREG, CLS_ADDIMM, CLS_SUBREG,
        CLS_SUBIMM, CLS_AND, CLS_ORR, CLS_CBZ, CLS_B, CLS_MOVZ
    } class_t;
endpackage

// File: rtl/ctrl_opcode_decode.sv
// ctrl_opcode_decode: combinational opcode field -> instruction class (CLS_NOP when undecodable)
module ctrl_opcode_decode
    import armv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output class_t      cls
);
    always_comb begin
        casez (opcode)
            OPCODE_LDUR:   cls = CLS_LDUR;
            OPCODE_STUR:   cls = CLS_STUR;
            OPCODE_ADDREG: cls = CLS_ADDREG;
            OPCODE_ADDIMM: cls = CLS_ADDIMM;
            OPCODE_SUBREG: cls = CLS_SUBREG;
            OPCODE_SUBIMM: cls = CLS_SUBIMM;
            OPCODE_AND:    cls = CLS_AND;
            OPCODE_ORR:    cls = CLS_ORR;
            OPCODE_CBZ:    cls = CLS_CBZ;
            OPCODE_B:      cls = CLS_B;
            OPCODE_MOVZ:   cls = CLS_MOVZ;
            default:       cls = CLS_NOP;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout and sticky illegal flag.
// Define MULTICYCLE_CTRL_PERF_EN to add the retired/stall_cycles performance counters.
module multicycle_control
    import armv8_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 11,
    parameter int ALUOP_W   = 4,
    parameter int SIGNOP_W  = 3,
    parameter int TIMEOUT_W = 8
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_write,
    output logic                ir_write,
    output logic                iord,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                pc_src,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [SIGNOP_W-1:0] signop,
    output logic                illegal,
    output logic [2:0]          state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]         retired,
    output logic [31:0]         stall_cycles
`endif
);
    state_t                 cur, nxt;
    class_t                 cls, cls_dec;
    logic [1:0]             hw;
    logic [TIMEOUT_W-1:0]   wait_cnt, cnt_inc;
    logic                   waiting, timeout;

    ctrl_opcode_decode u_dec (.opcode(opcode), .cls(cls_dec));

    assign state   = cur;
    assign waiting = cur == FETCH || cur == MEM;
    assign cnt_inc = wait_cnt + TIMEOUT_W'(1);
    // Timeout on the wait cycle that would saturate the counter; a same-cycle completion takes priority.
    assign timeout = waiting && !mem_ready && (&cnt_inc);

    always_comb begin
        nxt      = cur;
        pc_write = 1'b0;
        ir_write = 1'b0;
        iord     = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        pc_src   = 1'b0;
        aluop    = '0;
        signop   = '0;
        case (cur)
            FETCH: begin
                memread  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                nxt      = mem_ready ? DECODE : timeout ? HALT : FETCH;
            end
            DECODE: begin
                reg2loc = cls_dec == CLS_STUR || cls_dec == CLS_CBZ;
                nxt     = cls_dec == CLS_NOP ? HALT : EXEC;
            end
            EXEC: begin
                alusrc   = cls inside {CLS_LDUR, CLS_STUR, CLS_ADDIMM, CLS_SUBIMM, CLS_MOVZ};
                aluop    = cls inside {CLS_SUBREG, CLS_SUBIMM} ? ALUOP_SUB :
                           cls == CLS_ORR                      ? ALUOP_ORR :
                           cls inside {CLS_CBZ, CLS_MOVZ}      ? ALUOP_PASSB :
                           cls inside {CLS_AND, CLS_B}         ? ALUOP_AND : ALUOP_ADD;
                signop   = cls inside {CLS_ADDIMM, CLS_SUBIMM} ? SIGNOP_I :
                           cls == CLS_CBZ                      ? SIGNOP_CB :
                           cls == CLS_B                        ? SIGNOP_B :
                           cls == CLS_MOVZ                     ? {1'b1, hw} : SIGNOP_D;
                pc_src   = cls == CLS_B || cls == CLS_CBZ;
                pc_write = cls == CLS_B || (cls == CLS_CBZ && zero);
                nxt      = cls inside {CLS_B, CLS_CBZ}     ? FETCH :
                           cls inside {CLS_LDUR, CLS_STUR} ? MEM : WB;
            end
            MEM: begin
                iord     = 1'b1;
                memread  = cls == CLS_LDUR;
                memwrite = cls == CLS_STUR;
                nxt      = mem_ready ? (cls == CLS_LDUR ? WB : FETCH) : timeout ? HALT : MEM;
            end
            WB: begin
                regwrite = 1'b1;
                mem2reg  = cls == CLS_LDUR;
                nxt      = FETCH;
            end
            default: nxt = HALT;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cur      <= FETCH;
            cls      <= CLS_NOP;
            hw       <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= (waiting && !mem_ready) ? cnt_inc : '0;
            illegal  <= illegal | (nxt == HALT);
            if (cur == DECODE) begin
                cls <= cls_dec;
                hw  <= opcode[1:0];
            end
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            if (cur inside {EXEC, MEM, WB} && nxt == FETCH) retired <= retired + 32'd1;
            if (waiting && !mem_ready) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle vectors for the multicycle control FSM
module tb_multicycle_control;
    logic        CLK = 1'b0, reset = 1'b1, mem_ready = 1'b0, zero = 1'b0;
    logic [10:0] opcode = '0;
    logic        pc_write, ir_write, iord, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, pc_src;
    logic [3:0]  aluop;
    logic [2:0]  signop, state;
    logic        illegal;
    logic [9:0]  sb;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired, stall_cycles;
`endif
    int total = 0, bad = 0;

    // strobe vector: {pc_write, ir_write, iord, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, pc_src}
    localparam logic [9:0] F_WAIT = 10'b00000_00100;
    localparam logic [9:0] F_RDY  = 10'b11000_00100;
    localparam logic [9:0] R2L    = 10'b00010_00000;
    localparam logic [9:0] ASRC   = 10'b00001_00000;
    localparam logic [9:0] M_RD   = 10'b00100_00100;
    localparam logic [9:0] M_WR   = 10'b00100_00010;
    localparam logic [9:0] W_REG  = 10'b00000_01000;
    localparam logic [9:0] W_LD   = 10'b00000_11000;
    localparam logic [9:0] BR_T   = 10'b10000_00001;
    localparam logic [9:0] BR_N   = 10'b00000_00001;
    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5;

    assign sb = {pc_write, ir_write, iord, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, pc_src};

    multicycle_control dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .reg2loc(reg2loc), .alusrc(alusrc),
        .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .pc_src(pc_src),
        .aluop(aluop), .signop(signop), .illegal(illegal), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .retired(retired), .stall_cycles(stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc(input string tag, input logic mr, input logic z, input logic [2:0] st,
                       input logic [9:0] s, input logic [3:0] ao, input logic [2:0] so);
        mem_ready = mr;
        zero = z;
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".strobes"}, 32'(sb), 32'(s));
        chk({tag, ".aluop"}, 32'(aluop), 32'(ao));
        chk({tag, ".signop"}, 32'(signop), 32'(so));
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.state", 32'(state), 32'(SF));
        chk("rst.illegal", 32'(illegal), 0);
        chk("rst.strobes", 32'(sb), 32'(F_WAIT));
        reset = 1'b0;

        opcode = 11'b10001011000;
        cyc("add.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("add.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("add.e", 0, 0, SE, 10'b0, 4'b0010, 3'b000);
        cyc("add.wb", 0, 0, SW, W_REG, 4'b0000, 3'b000);

        opcode = 11'b10010001000;
        cyc("addi.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("addi.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("addi.e", 0, 0, SE, ASRC, 4'b0010, 3'b001);
        cyc("addi.wb", 0, 0, SW, W_REG, 4'b0000, 3'b000);

        opcode = 11'b11001011000;
        cyc("sub.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("sub.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("sub.e", 0, 0, SE, 10'b0, 4'b0110, 3'b000);
        cyc("sub.wb", 0, 0, SW, W_REG, 4'b0000, 3'b000);

        opcode = 11'b10101010000;
        cyc("orr.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("orr.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("orr.e", 0, 0, SE, 10'b0, 4'b0001, 3'b000);
        cyc("orr.wb", 0, 0, SW, W_REG, 4'b0000, 3'b000);

        opcode = 11'b10001010000;
        cyc("and.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("and.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("and.e", 0, 0, SE, 10'b0, 4'b0000, 3'b000);
        cyc("and.wb", 0, 0, SW, W_REG, 4'b0000, 3'b000);

        opcode = 11'b11010010110;
        cyc("movz.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("movz.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("movz.e", 0, 0, SE, ASRC, 4'b0111, 3'b110);
        cyc("movz.wb", 0, 0, SW, W_REG, 4'b0000, 3'b000);

        // mem_ready high in DECODE/EXEC must not disturb sequencing
        opcode = 11'b11111000010;
        cyc("ldur.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("ldur.d", 1, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("ldur.e", 1, 0, SE, ASRC, 4'b0010, 3'b000);
        cyc("ldur.m0", 0, 0, SM, M_RD, 4'b0000, 3'b000);
        cyc("ldur.m1", 0, 0, SM, M_RD, 4'b0000, 3'b000);
        cyc("ldur.m2", 1, 0, SM, M_RD, 4'b0000, 3'b000);
        cyc("ldur.wb", 0, 0, SW, W_LD, 4'b0000, 3'b000);

        opcode = 11'b11111000000;
        cyc("stur.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("stur.d", 0, 0, SD, R2L, 4'b0000, 3'b000);
        cyc("stur.e", 0, 0, SE, ASRC, 4'b0010, 3'b000);
        cyc("stur.m", 1, 0, SM, M_WR, 4'b0000, 3'b000);

        opcode = 11'b10110100101;
        cyc("cbzt.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("cbzt.d", 0, 0, SD, R2L, 4'b0000, 3'b000);
        cyc("cbzt.e", 0, 1, SE, BR_T, 4'b0111, 3'b010);
        cyc("cbzn.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("cbzn.d", 0, 0, SD, R2L, 4'b0000, 3'b000);
        cyc("cbzn.e", 0, 0, SE, BR_N, 4'b0111, 3'b010);

        opcode = 11'b00010100000;
        cyc("b.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("b.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("b.e", 0, 0, SE, BR_T, 4'b0000, 3'b011);
        chk("b.back", 32'(state), 32'(SF));
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("perf.retired", retired, 32'd11);
        chk("perf.stall", stall_cycles, 32'd2);
`endif

        opcode = 11'b11111000000;
        cyc("rst.stur.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("rst.stur.d", 0, 0, SD, R2L, 4'b0000, 3'b000);
        cyc("rst.stur.e", 0, 0, SE, ASRC, 4'b0010, 3'b000);
        cyc("rst.stur.m", 0, 0, SM, M_WR, 4'b0000, 3'b000);
        mem_ready = 1'b0;
        #1;
        chk("rst.mem.memwrite_pre", 32'(memwrite), 1);
        reset = 1'b1;
        #1;
        chk("rst.mem.memwrite", 32'(memwrite), 0);
        chk("rst.mem.state", 32'(state), 32'(SF));
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("rst.mem.retired", retired, 0);
        chk("rst.mem.stall", stall_cycles, 0);
`endif
        tick();
        reset = 1'b0;

        // ready arriving on the 255th wait cycle still completes the fetch
        opcode = 11'b10001011000;
        for (int i = 0; i < 254; i++) begin
            mem_ready = 1'b0;
            tick();
        end
        cyc("to.rdy.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("to.rdy.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        cyc("to.rdy.e", 0, 0, SE, 10'b0, 4'b0010, 3'b000);
        cyc("to.rdy.wb", 0, 0, SW, W_REG, 4'b0000, 3'b000);
        chk("to.rdy.illegal", 32'(illegal), 0);

        for (int i = 0; i < 254; i++) begin
            mem_ready = 1'b0;
            tick();
        end
        chk("to.pre.illegal", 32'(illegal), 0);
        cyc("to.last", 0, 0, SF, F_WAIT, 4'b0000, 3'b000);
        chk("to.illegal", 32'(illegal), 1);
        cyc("to.halt0", 1, 0, SH, 10'b0, 4'b0000, 3'b000);
        cyc("to.halt1", 1, 1, SH, 10'b0, 4'b0000, 3'b000);

        do_reset();
        chk("ill.rst.illegal", 32'(illegal), 0);
        opcode = 11'b00000000000;
        cyc("ill.f", 1, 0, SF, F_RDY, 4'b0000, 3'b000);
        cyc("ill.d", 0, 0, SD, 10'b0, 4'b0000, 3'b000);
        chk("ill.illegal", 32'(illegal), 1);
        cyc("ill.h0", 1, 0, SH, 10'b0, 4'b0000, 3'b000);
        cyc("ill.h1", 0, 1, SH, 10'b0, 4'b0000, 3'b000);
        chk("ill.sticky", 32'(illegal), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
